// File: rtl/regfile_pkg.sv
// regfile_mp shared constants and types.
// Optional bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_READ   = 2;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    SWEEP,
    RUN
  } sweep_state_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback side bundle of the register file.
// Master drives addresses and strobes; slave returns data.
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) ();

  logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_pending;
  logic                           write_enable;
  logic [ADDR_WIDTH-1:0]          write_address;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           reserve_en;
  logic [ADDR_WIDTH-1:0]          reserve_address;
  logic                           ready;

  modport master (
    output read_address,
    output write_enable,
    output write_address,
    output write_data,
    output reserve_en,
    output reserve_address,
    input  read_data,
    input  read_pending,
    input  ready
  );

  modport slave (
    input  read_address,
    input  write_enable,
    input  write_address,
    input  write_data,
    input  reserve_en,
    input  reserve_address,
    output read_data,
    output read_pending,
    output ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register with per-port lookup.
// A same-cycle set beats a clear: it is the newer producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ready,
  input  logic                           set_en,
  input  logic [ADDR_WIDTH-1:0]          set_addr,
  input  logic                           clr_en,
  input  logic [ADDR_WIDTH-1:0]          clr_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr,
  output logic [NUM_READ-1:0]            lookup_pending
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR =
    ADDR_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0] pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (ready) begin
      if (clr_en && clr_addr != ZR)
        pending[clr_addr] <= 1'b0;
      if (set_en && set_addr != ZR)
        pending[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    lookup_pending = '0;
    for (int k = 0; k < NUM_READ; k++)
      lookup_pending[k] = ready &
        pending[lookup_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port RV32I register file with clear sweep.
// REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ
) (
  input  logic     clk,
  input  logic     reset_n,
  regfile_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR =
    ADDR_WIDTH'(ZERO_REG);

  sweep_state_t          state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  ready;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] rdata;
  logic                  wr;

  assign wr = ready && bus.write_enable &&
              bus.write_address != ZR;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SWEEP;
      idx   <= ADDR_WIDTH'(1);
      ready <= 1'b0;
    end else begin
      unique case (state)
        SWEEP: begin
          idx <= idx + 1'b1;
          if (&idx) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: state <= RUN;
        default: state <= SWEEP;
      endcase
    end
  end

  // x0 is never stored; the read mux forces it to zero
  always_ff @(posedge clk) begin
    if (state == SWEEP)
      regs[idx] <= '0;
    else if (wr)
      regs[bus.write_address] <= bus.write_data;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (ready &&
          bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH] != ZR) begin
        rdata[k*DATA_WIDTH +: DATA_WIDTH] =
          regs[bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        if (wr && bus.write_address ==
            bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH])
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
`endif
      end
    end
  end

  assign bus.read_data = rdata;
  assign bus.ready     = ready;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_sb (
    .clk            (clk),
    .reset_n        (reset_n),
    .ready          (ready),
    .set_en         (bus.reserve_en),
    .set_addr       (bus.reserve_address),
    .clr_en         (bus.write_enable),
    .clr_addr       (bus.write_address),
    .lookup_addr    (bus.read_address),
    .lookup_pending (bus.read_pending)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RV32I core, the successor to the current two-read/one-write file. It sits between decode (read ports, reservation) and writeback (write port). It adds an asynchronous active-low reset with a sequential clear sweep, a per-register pending-write scoreboard, and optional write-to-read bypass. Register 0 reads as zero at all times.

## Interface
Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, address width; depth is 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports, legal range 1..4.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  reset; asynchronous assert, active-low.
- read_address  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  output  NUM_READ*DATA_WIDTH  packed read data, combinational.
- read_pending  output  NUM_READ  pending bit of the register addressed by each read port.
- write_enable  input  1  write strobe.
- write_address  input  ADDR_WIDTH  write target.
- write_data  input  DATA_WIDTH  write value.
- reserve_en  input  1  mark reserve_address as awaiting a write.
- reserve_address  input  ADDR_WIDTH  register to reserve.
- ready  output  1  clear sweep finished; the file is usable.

## Operation
- Reset (reset_n=0): ready=0, sweep index=1, all pending bits=0, immediately and asynchronously. Register contents are undefined until the sweep clears them.
- States:
  - SWEEP: each rising edge writes 0 to register[index] and increments index. The edge that clears index 2**ADDR_WIDTH-1 moves the state to RUN and sets ready=1.
  - RUN: normal operation. The state stays RUN until the next reset.
- Reset asserted mid-sweep: restart from index 1.
- While ready=0:
  - read_data = 0 and read_pending = 0 on every port.
  - Writes and reservations are dropped and leave no pending state.
- Write in RUN: when write_enable=1 and write_address≠0, register[write_address] is updated at the rising edge and pending[write_address] is cleared. Writes to address 0 are discarded.
- Reservation in RUN: when reserve_en=1 and reserve_address≠0, pending[reserve_address] is set at the edge. Reservations of address 0 are ignored; pending[0] is always 0.
- Reserve and write to the same address in the same cycle: the register takes the data and the pending bit ends up 1. The reservation wins, since it represents a newer producer.
- Reads:
  - read_data[k] = register[read_address k].
  - Port address 0 returns 0.
  - All ports are independent; any ports may alias the same address.
- read_pending[k] = pending[read_address k]. This is combinational and reflects the current registered state, not a write in the same cycle.

## Timing
- Read data and pending outputs: zero-cycle combinational from the addresses and state.
- Write is visible on reads the cycle after the write edge, or the same cycle when bypass is compiled in.
- ready rises exactly 2**ADDR_WIDTH-1 rising edges after reset_n deasserts (31 edges at the default).
- Reset to outputs: ready, read_data and read_pending are 0 asynchronously while reset_n=0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: when write_enable=1, ready=1, write_address≠0 and write_address equals read_address k, read_data[k] = write_data in the same cycle. read_pending is unaffected by bypass.
- Undefined: read_data[k] returns the stored value, which is the old value until the write edge.

## Structure
- Package regfile_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH/NUM_READ constants;
  - ZERO_REG constant (address 0);
  - sweep state enum (SWEEP, RUN).
- Sub-module regfile_scoreboard holds the pending bit vector.
  - Inputs: set and clear ports plus ready.
  - Outputs: NUM_READ lookup outputs.
- Storage array, sweep counter and read muxes live in regfile_mp.

## Test plan
- Reset sweep:
  - pulse reset_n low, release, hold reads of x5 and x31;
  - read_data=0 and ready=0 for 30 edges; ready=1 after edge 31; x5 and x31 read 0.
- Write/read:
  - in RUN, write x7=0xDEADBEEF, read x7 on both ports;
  - without bypass: old value (0) that cycle, 0xDEADBEEF next cycle;
  - with REGFILE_BYPASS_EN: 0xDEADBEEF same cycle.
- x0 protection:
  - write x0=0xFFFFFFFF and reserve x0;
  - x0 reads 0; read_pending for x0 stays 0.
- Scoreboard:
  - reserve x3; next cycle read_pending=1 for x3;
  - write x3=0x10; next cycle read_pending=0 and data=0x10;
  - reserve and write x4 in the same cycle leaves pending=1.
- Reset mid-sweep:
  - assert reset_n at sweep edge 10, release;
  - ready rises 31 edges after the second release, not earlier.
- Writes before ready:
  - write x9=0x55 during SWEEP;
  - after ready, x9 reads 0 and pending is 0.
